alu_bist: RTL
=============

Name: alu_bist

Overview:
- Synthesizable built-in self-test controller for the RV32I ALU.
- It is the driver/monitor end of the ALU interface. It generates op1/op2/ALUop stimulus, samples ALUresult, and compares it against an internal reference model.
- It sits beside the ALU in the datapath test harness. The op1/op2/ALUop muxes select this block's outputs when busy=1.
- It reports pass/fail, a saturating failure count, and the first failing op and vector.

Parameters:
- NUM_VECTORS, 16, vectors applied per ALUop (1..256).
- SEED, 32'h1ACE_B00C, LFSR value loaded on start; must be non-zero.
- NUM_OPS, 10, number of ALUop codes exercised, from 0 to NUM_OPS-1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a test run; ignored while busy.
- op1  out  32  operand A to ALU.
- op2  out  32  operand B to ALU.
- ALUop  out  4  operation code to ALU.
- ALUresult  in  32  combinational ALU output.
- busy  out  1  high from the cycle after start until done asserts.
- done  out  1  high when a run has completed; held until next start or reset.
- pass  out  1  valid when done=1; 1 if no mismatch occurred.
- fail_count  out  8  number of mismatches, saturating at 255.
- fail_op  out  4  ALUop of the first mismatch.
- fail_idx  out  8  vector index of the first mismatch.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: op1=0, op2=0, ALUop=0, busy=0, done=0, pass=0, fail_count=0, fail_op=0, fail_idx=0.
  - FSM goes to IDLE and the LFSR is loaded with SEED.
  - Reset mid-run aborts immediately; no partial result is retained.
- ALU encoding (fixed codebase map):
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - Shifts use op2[4:0]. SLT/SLTU return 32'h0 or 32'h1. Add/sub wrap modulo 2^32.
  - Codes >= NUM_OPS are never driven.
- FSM states: IDLE, APPLY, CHECK, DONE.
  - IDLE:
    - On start=1: LFSR<=SEED, op index<=0, vector index<=0, fail_count<=0, first-fail flag cleared.
    - busy<=1, done<=0, next state APPLY.
  - APPLY:
    - Registers op1/op2/ALUop for the current vector; next state CHECK.
  - CHECK:
    - ALUresult is combinationally valid for the registered operands.
    - The block computes expected from registered op1/op2/ALUop, then compares.
    - On mismatch: fail_count increments, saturating at 255. If this is the first mismatch, capture fail_op=ALUop and fail_idx=vector index, and set the flag.
    - The LFSR advances one step.
    - If vector index=NUM_VECTORS-1: vector index<=0 and op index increments. Otherwise vector index increments.
    - If the last vector of op NUM_OPS-1 was checked: next state DONE. Otherwise next state APPLY.
  - DONE:
    - busy=0, done=1, pass=(fail_count==0).
    - op1/op2/ALUop hold their last values.
    - start=1 restarts exactly as from IDLE. Results are cleared on the cycle the run begins.
- Run timing:
  - 2 cycles per vector.
  - The run length from the start edge to the done rising edge is exactly 2*NUM_OPS*NUM_VECTORS + 1 cycles (default 321).
- Stimulus:
  - Vector 0 of every op: op1=32'h8000_0000, op2=32'hFFFF_FFFF (sign/shift corner).
  - Vectors 1..N-1: op1=lfsr; op2={lfsr[15:0],lfsr[31:16]} ^ 32'hA5A5_A5A5.
  - LFSR: 32-bit Galois, shift right; if the shifted-out bit=1, XOR with 32'h8020_0003.
  - The LFSR advances in every CHECK, including vector 0, and is not reset between ops.
- start is ignored in APPLY/CHECK: no restart, no effect on counters.
- When NUM_VECTORS=1, only corner vectors are applied.

Test Plan:
- Golden ALU connected, default parameters, start pulse:
  - busy rises next cycle; done rises exactly 321 cycles after the start edge.
  - pass=1, fail_count=0.
  - Monitor the first APPLY: op1=32'h8000_0000, op2=32'hFFFF_FFFF, ALUop=0.
- Vector 1 of op 0:
  - op1 equals SEED advanced once.
  - op2 equals the rotate/XOR of that value.
  - Check against a bench LFSR model.
- Fault-injected ALU (ADD result bit 0 forced to 0):
  - pass=0, fail_op=0.
  - fail_idx equals the first vector whose true sum is odd. For vector 0, 0x8000_0000+0xFFFF_FFFF=0x7FFF_FFFF is odd, so fail_idx=0.
  - fail_count equals the number of odd sums across op 0 vectors.
- ALU returning constant 0 for all ops:
  - fail_count equals the total number of non-zero expected results, which is at least 100 for the defaults (check against the bench model).
  - Saturation check: NUM_VECTORS=64 must show fail_count=255.
- start pulsed during CHECK of op 3:
  - No restart; completion timing is unchanged (321 cycles).
  - A second start in DONE clears done/fail_count and reruns identically.
- rst_n pulled low mid-run (op 5):
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, the block idles until start; the next run reproduces the identical vector sequence.

Source files
------------

// File: rtl/alu_bist.sv
// -----------------------------------------------------------------------------
// alu_bist : built-in self-test controller for the RV32I ALU.
//
// Drives op1/op2/ALUop into the ALU, samples the combinational ALUresult one
// cycle later and compares it against an internal reference model. Each run
// sweeps ALUop 0..NUM_OPS-1 with NUM_VECTORS vectors per op. Vector 0 of every
// op is a fixed sign/shift corner case. The remaining vectors come from a
// 32-bit Galois LFSR.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   one-cycle pulse that begins a run (ignored while busy)
//   op1        out  32  operand A to ALU
//   op2        out  32  operand B to ALU
//   ALUop      out  4   operation code to ALU
//   ALUresult  in   32  combinational ALU output
//   busy       out  1   high from the cycle after start until done asserts
//   done       out  1   run complete; held until next start or reset
//   pass       out  1   valid with done; 1 when no mismatch was seen
//   fail_count out  8   mismatch count, saturating at 255
//   fail_op    out  4   ALUop of the first mismatch
//   fail_idx   out  8   vector index of the first mismatch
// -----------------------------------------------------------------------------
module alu_bist #(
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'h1ACE_B00C,
  parameter int          NUM_OPS     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [3:0]  ALUop,
  input  logic [31:0] ALUresult,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_count,
  output logic [3:0]  fail_op,
  output logic [7:0]  fail_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0]  LAST_VEC   = 8'(NUM_VECTORS - 1);
  localparam logic [3:0]  LAST_OP    = 4'(NUM_OPS - 1);
  localparam logic [31:0] CORNER_A   = 32'h8000_0000;
  localparam logic [31:0] CORNER_B   = 32'hFFFF_FFFF;
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] OP2_MASK   = 32'hA5A5_A5A5;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    logic [31:0] nxt;
    nxt = {1'b0, cur[31:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // Reference ALU using the codebase opcode map.
  function automatic logic [31:0] alu_ref(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  op);
    logic [31:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << b[4:0];
      4'd3:    r = {31'd0, ($signed(a) < $signed(b))};
      4'd4:    r = {31'd0, (a < b)};
      4'd5:    r = a ^ b;
      4'd6:    r = a >> b[4:0];
      4'd7:    r = $unsigned($signed(a) >>> b[4:0]);
      4'd8:    r = a | b;
      4'd9:    r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [31:0] lfsr_r;
  logic [3:0]  opidx_r;
  logic [7:0]  vidx_r;
  logic        first_fail_r;
  logic [31:0] op1_r;
  logic [31:0] op2_r;
  logic [3:0]  aluop_r;
  logic        busy_r;
  logic        done_r;
  logic        pass_r;
  logic [7:0]  fail_count_r;
  logic [3:0]  fail_op_r;
  logic [7:0]  fail_idx_r;

  logic        start_run_s;
  logic        last_vec_s;
  logic        last_op_s;
  logic [31:0] expected_s;
  logic        mismatch_s;

  // A run may only begin from IDLE or DONE; start is ignored mid-run.
  assign start_run_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_vec_s  = (vidx_r == LAST_VEC);
  assign last_op_s   = (opidx_r == LAST_OP);
  assign expected_s  = alu_ref(op1_r, op2_r, aluop_r);
  assign mismatch_s  = (ALUresult != expected_s);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = APPLY;
        end else begin
          state_s = IDLE;
        end
      end
      APPLY: state_s = CHECK;
      CHECK: begin
        if (last_vec_s && last_op_s) begin
          state_s = DONE;
        end else begin
          state_s = APPLY;
        end
      end
      DONE: begin
        if (start) begin
          state_s = APPLY;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Stimulus generation, result checking and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r       <= SEED;
      opidx_r      <= 4'd0;
      vidx_r       <= 8'd0;
      first_fail_r <= 1'b0;
      op1_r        <= 32'd0;
      op2_r        <= 32'd0;
      aluop_r      <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_count_r <= 8'd0;
      fail_op_r    <= 4'd0;
      fail_idx_r   <= 8'd0;
    end else if (start_run_s) begin
      lfsr_r       <= SEED;
      opidx_r      <= 4'd0;
      vidx_r       <= 8'd0;
      first_fail_r <= 1'b0;
      busy_r       <= 1'b1;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_count_r <= 8'd0;
      fail_op_r    <= 4'd0;
      fail_idx_r   <= 8'd0;
    end else begin
      case (state_r)
        APPLY: begin
          aluop_r <= opidx_r;
          if (vidx_r == 8'd0) begin
            op1_r <= CORNER_A;
            op2_r <= CORNER_B;
          end else begin
            op1_r <= lfsr_r;
            op2_r <= {lfsr_r[15:0], lfsr_r[31:16]} ^ OP2_MASK;
          end
        end
        CHECK: begin
          if (mismatch_s) begin
            if (fail_count_r != 8'hFF) begin
              fail_count_r <= fail_count_r + 8'd1;
            end
            if (!first_fail_r) begin
              first_fail_r <= 1'b1;
              fail_op_r    <= aluop_r;
              fail_idx_r   <= vidx_r;
            end
          end
          // LFSR steps on every check, corner vectors included.
          lfsr_r <= lfsr_step(lfsr_r);
          if (last_vec_s) begin
            vidx_r  <= 8'd0;
            opidx_r <= opidx_r + 4'd1;
          end else begin
            vidx_r  <= vidx_r + 8'd1;
          end
        end
        DONE: begin
          // Results publish one cycle after entering DONE.
          busy_r <= 1'b0;
          done_r <= 1'b1;
          pass_r <= (fail_count_r == 8'd0);
        end
        default: begin
          busy_r <= busy_r;
        end
      endcase
    end
  end

  assign op1        = op1_r;
  assign op2        = op2_r;
  assign ALUop      = aluop_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign fail_count = fail_count_r;
  assign fail_op    = fail_op_r;
  assign fail_idx   = fail_idx_r;

endmodule
